// File: rtl/dl_reg_wr_arb_pkg.sv
// Shared constants and helpers for the shared-register write arbiter.
// Optional per-requester grant statistics: DL_REG_WR_ARB_STATS_EN.
package dl_reg_wr_arb_pkg;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam int STAT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dl_reg_en_rst.sv
// Enabled register with synchronous active-low reset.
// Reset value is a parameter; reset wins over enable.
module dl_reg_en_rst #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // storage: reset dominates, else load on enable
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dl_rr_arb.sv
// Combinational round-robin pick starting at ptr.
// Returns one-hot grant, its index and an any-request flag.
module dl_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // scan from farthest to nearest so the nearest request wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/dl_reg_wr_arb.sv
// Round-robin write arbiter with lock and watchdog over one shared register.
// Define DL_REG_WR_ARB_STATS_EN to add per-requester grant counters.
module dl_reg_wr_arb
  import dl_reg_wr_arb_pkg::*;
#(
  parameter int                 NUM_REQ  = 4,
  parameter int                 NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RST_VAL = '0,
  parameter int                 LOCK_MAX = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*NUM_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_BITS-1:0]         q,
  output logic [idx_w(NUM_REQ)-1:0]   q_owner,
  output logic                        upd,
  output logic                        locked,
  output logic                        lock_expired
`ifdef DL_REG_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]   grant_cnt
`endif
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(LOCK_MAX);

  logic [0:0]          state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       owner;
  logic [CW-1:0]       lock_cnt;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  logic [IW-1:0]       win_idx;
  logic                acc;
  logic [NUM_BITS-1:0] win_data;
  logic [IW-1:0]       nxt_ptr;
  logic                wd_hit;

  dl_rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // grant: owner only while locked, round-robin otherwise
  always_comb begin
    req_ready = '0;
    win_idx   = arb_idx;
    acc       = arb_any;
    if (state == LOCK) begin
      win_idx          = owner;
      acc              = req_valid[owner];
      req_ready[owner] = req_valid[owner];
    end else begin
      req_ready = arb_gnt;
    end
  end

  // winner data and derived next-state helpers
  always_comb begin
    win_data = req_data[int'(win_idx)*NUM_BITS +: NUM_BITS];
    nxt_ptr  = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    wd_hit   = (lock_cnt == CW'(LOCK_MAX - 1));
  end

  dl_reg_en_rst #(
    .W       (NUM_BITS),
    .RST_VAL (RST_VAL)
  ) u_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc),
    .d     (win_data),
    .q     (q)
  );

  // arbitration state, lock tracking and watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB;
      rr_ptr       <= '0;
      owner        <= '0;
      lock_cnt     <= '0;
      q_owner      <= '0;
      upd          <= 1'b0;
      lock_expired <= 1'b0;
    end else begin
      upd          <= acc;
      lock_expired <= 1'b0;
      if (acc) begin
        q_owner <= win_idx;
        rr_ptr  <= nxt_ptr;
      end
      if (state == ARB) begin
        if (acc && req_lock[win_idx]) begin
          state    <= LOCK;
          owner    <= win_idx;
          lock_cnt <= '0;
        end
      end else if (!req_lock[owner]) begin
        state    <= ARB;
        lock_cnt <= '0;
      end else if (wd_hit) begin
        state        <= ARB;
        lock_cnt     <= '0;
        lock_expired <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  assign locked = (state == LOCK);

`ifdef DL_REG_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;

    // saturating count of accepted writes by requester i
    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt <= '0;
      else if (acc && win_idx == IW'(i) && cnt != '1)
        cnt <= cnt + 1'b1;
    end

    assign grant_cnt[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_dl_reg_wr_arb.sv
// Self-checking bench for dl_reg_wr_arb: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_dl_reg_wr_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LM = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_lock;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   q;
  logic [1:0]     q_owner;
  logic           upd;
  logic           locked;
  logic           lock_expired;
`ifdef DL_REG_WR_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ptr, m_own, m_cnt, m_qown;
  bit          m_lock, m_upd, m_exp;
  logic [W-1:0] m_q;

  dl_reg_wr_arb #(
    .NUM_REQ  (N),
    .NUM_BITS (W),
    .RST_VAL  (32'h0),
    .LOCK_MAX (LM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_lock     (req_lock),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .q            (q),
    .q_owner      (q_owner),
    .upd          (upd),
    .locked       (locked),
    .lock_expired (lock_expired)
`ifdef DL_REG_WR_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_ready();
    logic [N-1:0] r;
    int j;
    r = '0;
    if (m_lock) begin
      if (req_valid[m_own]) r[m_own] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (req_valid[j]) begin
          r[j] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic tick();
    logic [N-1:0] g;
    int win;
    g = ref_ready();
    @(posedge clk);
    if (!rst_n) begin
      m_q = '0; m_qown = 0; m_ptr = 0; m_lock = 0;
      m_upd = 0; m_exp = 0; m_cnt = 0; m_own = 0;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) if (g[k]) win = k;
      m_exp = 0;
      m_upd = (win >= 0);
      if (win >= 0) begin
        m_q    = req_data[win*W +: W];
        m_qown = win;
        m_ptr  = (win + 1) % N;
      end
      if (!m_lock) begin
        if (win >= 0 && req_lock[win]) begin
          m_lock = 1; m_cnt = 0; m_own = win;
        end
      end else if (!req_lock[m_own]) begin
        m_lock = 0;
      end else if (m_cnt == LM - 1) begin
        m_lock = 0; m_exp = 1;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic set_seq_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'(i + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_lock = 4'h0;
    set_seq_data();
    tick(); tick();
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL reset_q got %h exp %h", q, 32'h0);
    end
    checks++;
    if (upd !== 1'b0 || locked !== 1'b0 || lock_expired !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got upd=%b lk=%b ex=%b exp 0 0 0",
               upd, locked, lock_expired);
    end
    checks++;
    if (q_owner !== 2'd0) begin
      errors++; $display("FAIL reset_owner got %0d exp 0", q_owner);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_ready got %b exp 0001", req_ready);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b1; req_valid = 4'hF; req_lock = 4'h0;
    set_seq_data();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp_g[i])) begin
        errors++;
        $display("FAIL rr_ready[%0d] got %b exp %b", i, req_ready,
                 4'(1 << exp_g[i]));
      end
      tick();
      checks++;
      if (q !== 32'(exp_g[i] + 1) || q_owner !== 2'(exp_g[i]) || upd !== 1'b1) begin
        errors++;
        $display("FAIL rr_q[%0d] got q=%h own=%0d upd=%b exp q=%h own=%0d upd=1",
                 i, q, q_owner, upd, exp_g[i] + 1, exp_g[i]);
      end
    end
  endtask

  task automatic test_wrap_skip();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_ready got %b exp 0001", req_ready);
    end
    tick();
    checks++;
    if (q_owner !== 2'd0) begin
      errors++; $display("FAIL wrap_owner0 got %0d exp 0", q_owner);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL skip_ready got %b exp 0100", req_ready);
    end
    tick();
    checks++;
    if (q_owner !== 2'd2) begin
      errors++; $display("FAIL skip_owner2 got %0d exp 2", q_owner);
    end
  endtask

  task automatic test_lock();
    req_valid = 4'b0010; req_lock = 4'b0010;
    req_data[1*W +: W] = 32'hA5;
    tick();
    checks++;
    if (q !== 32'hA5 || locked !== 1'b1 || q_owner !== 2'd1) begin
      errors++;
      $display("FAIL lock_enter got q=%h lk=%b own=%0d exp q=a5 lk=1 own=1",
               q, locked, q_owner);
    end
    req_valid = 4'hF; req_data[1*W +: W] = 32'h5A;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL lock_only_owner got %b exp 0010", req_ready);
    end
    tick();
    checks++;
    if (q !== 32'h5A || locked !== 1'b1) begin
      errors++; $display("FAIL lock_write got q=%h lk=%b exp 5a 1", q, locked);
    end
    req_valid = 4'b1101;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL lock_block got %b exp 0000", req_ready);
    end
    tick();
    req_lock = 4'b0000;
    tick();
    checks++;
    if (locked !== 1'b0 || upd !== 1'b0) begin
      errors++; $display("FAIL lock_release got lk=%b upd=%b exp 0 0", locked, upd);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL lock_next got %b exp 0100", req_ready);
    end
    tick();
  endtask

  task automatic test_watchdog();
    req_valid = 4'b1000; req_lock = 4'b1000;
    tick();
    req_valid = 4'b0111;
    for (int i = 1; i <= LM; i++) begin
      tick();
      checks++;
      if (i < LM && (locked !== 1'b1 || lock_expired !== 1'b0)) begin
        errors++;
        $display("FAIL wd_hold[%0d] got lk=%b ex=%b exp 1 0", i, locked, lock_expired);
      end else if (i == LM && (locked !== 1'b0 || lock_expired !== 1'b1)) begin
        errors++;
        $display("FAIL wd_fire got lk=%b ex=%b exp 0 1", locked, lock_expired);
      end
    end
    req_lock = 4'b0000;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL wd_resume got %b exp 0001", req_ready);
    end
    tick();
    checks++;
    if (lock_expired !== 1'b0 || q_owner !== 2'd0) begin
      errors++;
      $display("FAIL wd_pulse got ex=%b own=%0d exp 0 0", lock_expired, q_owner);
    end
  endtask

  task automatic test_reset_mid_lock();
    req_valid = 4'b0100; req_lock = 4'b0100;
    tick();
    req_data[2*W +: W] = 32'hDEAD;
    rst_n = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b0 || q !== 32'h0 || upd !== 1'b0) begin
      errors++;
      $display("FAIL rst_lock got lk=%b q=%h upd=%b exp 0 0 0", locked, q, upd);
    end
    rst_n = 1'b1; req_valid = 4'hF; req_lock = 4'h0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_lock_ptr got %b exp 0001", req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      req_valid = 4'($urandom);
      req_lock  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
      #1;
      checks++;
      if (req_ready !== ref_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d] got %b exp %b", c, req_ready, ref_ready());
      end
      tick();
      checks++;
      if (q !== m_q || q_owner !== 2'(m_qown) || upd !== m_upd ||
          locked !== m_lock || lock_expired !== m_exp) begin
        errors++;
        $display("FAIL rand_out[%0d] got q=%h own=%0d upd=%b lk=%b ex=%b exp q=%h own=%0d upd=%b lk=%b ex=%b",
                 c, q, q_owner, upd, locked, lock_expired,
                 m_q, m_qown, m_upd, m_lock, m_exp);
      end
    end
  endtask

`ifdef DL_REG_WR_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; req_valid = 4'h0; req_lock = 4'h0;
    tick();
    rst_n = 1'b1; req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (grant_cnt[15:0] !== 16'd10) begin
      errors++; $display("FAIL stats_cnt got %0d exp 10", grant_cnt[15:0]);
    end
    for (int i = 10; i < 70000; i++) tick();
    checks++;
    if (grant_cnt[15:0] !== 16'hFFFF || grant_cnt[31:16] !== 16'h0) begin
      errors++;
      $display("FAIL stats_sat got %h/%h exp ffff/0000",
               grant_cnt[15:0], grant_cnt[31:16]);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = '0; req_lock = '0; req_data = '0;
    m_ptr = 0; m_own = 0; m_cnt = 0; m_qown = 0;
    m_lock = 0; m_upd = 0; m_exp = 0; m_q = '0;
    #1;
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_lock();
    test_watchdog();
    test_reset_mid_lock();
    test_random();
`ifdef DL_REG_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
